// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer.
// Entry tags are held zero-extended to the widest possible tag so one struct serves every ENTRIES value.
package btb_pkg;

    localparam int unsigned PC_W      = 16;
    localparam int unsigned TAG_MAX_W = PC_W - 1;

    localparam logic [1:0] BTB_CTR_RST   = 2'b01;
    localparam logic [1:0] BTB_CTR_ALLOC = 2'b10;

    function automatic int unsigned btb_tag_w(input int unsigned idx_w);
        return PC_W - idx_w;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [PC_W-1:0]      target;
        logic [1:0]           ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb_sat_ctr.sv
// 2-bit saturating up/down counter next-state function.
module btb_sat_ctr (
    input  logic [1:0] ctr,
    input  logic       up,
    output logic [1:0] ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        if (up) begin
            if (ctr != 2'b11) ctr_nxt = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) ctr_nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit predictors and a hit-flag pipeline to ID_EX.
// Optional BTB_STATS_EN adds saturating lookup/hit/redirect counters.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter  int unsigned ENTRIES = 16,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic        stall_IM_ID,
    input  logic        flow_change_ID_EX,
    input  logic        upd_en,
    input  logic [15:0] upd_pc,
    input  logic        upd_taken,
    input  logic [15:0] upd_target,
    output logic        btb_hit,
    output logic [15:0] btb_nxt_pc,
    output logic        btb_hit_ID_EX
`ifdef BTB_STATS_EN
    ,
    output logic [15:0] stat_lookups,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_redirects
`endif
);

    localparam int unsigned TAG_W = btb_tag_w(IDX_W);

    btb_entry_t        table_q [ENTRIES];
    btb_entry_t        look_e;
    btb_entry_t        upd_e;
    logic [IDX_W-1:0]  look_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  look_tag;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_match;
    logic [1:0]        ctr_nxt;
    logic              hit_im_id;

    assign look_idx = pc[IDX_W-1:0];
    assign look_tag = pc[PC_W-1:IDX_W];
    assign upd_idx  = upd_pc[IDX_W-1:0];
    assign upd_tag  = upd_pc[PC_W-1:IDX_W];

    // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
    always_comb begin
        look_e     = table_q[look_idx];
        btb_hit    = look_e.valid && (look_e.tag == TAG_MAX_W'(look_tag)) && look_e.ctr[1];
        btb_nxt_pc = btb_hit ? look_e.target : '0;
    end

    always_comb begin
        upd_e     = table_q[upd_idx];
        upd_match = upd_e.valid && (upd_e.tag == TAG_MAX_W'(upd_tag));
    end

    btb_sat_ctr u_sat_ctr (
        .ctr     (upd_e.ctr),
        .up      (upd_taken),
        .ctr_nxt (ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BTB_CTR_RST};
            end
        end else if (upd_en) begin
            if (upd_match) begin
                table_q[upd_idx].ctr <= ctr_nxt;
                if (upd_taken) table_q[upd_idx].target <= upd_target;
            end else if (upd_taken) begin
                table_q[upd_idx] <= '{valid: 1'b1, tag: TAG_MAX_W'(upd_tag),
                                      target: upd_target, ctr: BTB_CTR_ALLOC};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_im_id     <= 1'b0;
            btb_hit_ID_EX <= 1'b0;
        end else if (flow_change_ID_EX) begin
            hit_im_id     <= 1'b0;
            btb_hit_ID_EX <= 1'b0;
        end else if (stall_IM_ID) begin
            btb_hit_ID_EX <= 1'b0;
        end else begin
            hit_im_id     <= btb_hit;
            btb_hit_ID_EX <= hit_im_id;
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups   <= '0;
            stat_hits      <= '0;
            stat_redirects <= '0;
        end else begin
            if (!stall_IM_ID && stat_lookups != '1) stat_lookups <= stat_lookups + 16'd1;
            if (!stall_IM_ID && btb_hit && stat_hits != '1) stat_hits <= stat_hits + 16'd1;
            if (flow_change_ID_EX && stat_redirects != '1) stat_redirects <= stat_redirects + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer (ENTRIES=16): stimulus pushes expectations, a negedge monitor checks.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc = '0;
    logic        stall_IM_ID = 1'b0;
    logic        flow_change_ID_EX = 1'b0;
    logic        upd_en = 1'b0;
    logic [15:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [15:0] upd_target = '0;
    logic        btb_hit;
    logic [15:0] btb_nxt_pc;
    logic        btb_hit_ID_EX;
`ifdef BTB_STATS_EN
    logic [15:0] stat_lookups;
    logic [15:0] stat_hits;
    logic [15:0] stat_redirects;
`endif

    branch_target_buffer #(.ENTRIES(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc                (pc),
        .stall_IM_ID       (stall_IM_ID),
        .flow_change_ID_EX (flow_change_ID_EX),
        .upd_en            (upd_en),
        .upd_pc            (upd_pc),
        .upd_taken         (upd_taken),
        .upd_target        (upd_target),
        .btb_hit           (btb_hit),
        .btb_nxt_pc        (btb_nxt_pc),
        .btb_hit_ID_EX     (btb_hit_ID_EX)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups      (stat_lookups),
        .stat_hits         (stat_hits),
        .stat_redirects    (stat_redirects)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [3:0]  ck;    // [0] hit, [1] nxt_pc, [2] hit_ID_EX, [3] stats
        logic        hit;
        logic [15:0] nxt;
        logic        idex;
        logic [15:0] sl;
        logic [15:0] sh;
        logic [15:0] sr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic        stat_chk = 1'b0;
    logic [15:0] exp_sl = '0;
    logic [15:0] exp_sh = '0;
    logic [15:0] exp_sr = '0;

    task automatic step(input string nm, input logic r, input logic [15:0] p,
                        input logic st, input logic fl,
                        input logic ue, input logic [15:0] up, input logic ut, input logic [15:0] utg,
                        input logic [2:0] ck, input logic eh, input logic [15:0] en, input logic ei);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; pc = p; stall_IM_ID = st; flow_change_ID_EX = fl;
        upd_en = ue; upd_pc = up; upd_taken = ut; upd_target = utg;
        e.nm = nm; e.ck = {stat_chk, ck}; e.hit = eh; e.nxt = en; e.idex = ei;
        e.sl = exp_sl; e.sh = exp_sh; e.sr = exp_sr;
        stat_chk = 1'b0;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.ck[0]) begin
                checks++;
                if (btb_hit !== e.hit) begin
                    errors++;
                    $display("FAIL %s btb_hit: got %b expected %b", e.nm, btb_hit, e.hit);
                end
            end
            if (e.ck[1]) begin
                checks++;
                if (btb_nxt_pc !== e.nxt) begin
                    errors++;
                    $display("FAIL %s btb_nxt_pc: got %h expected %h", e.nm, btb_nxt_pc, e.nxt);
                end
            end
            if (e.ck[2]) begin
                checks++;
                if (btb_hit_ID_EX !== e.idex) begin
                    errors++;
                    $display("FAIL %s btb_hit_ID_EX: got %b expected %b", e.nm, btb_hit_ID_EX, e.idex);
                end
            end
`ifdef BTB_STATS_EN
            if (e.ck[3]) begin
                checks++;
                if (stat_lookups !== e.sl || stat_hits !== e.sh || stat_redirects !== e.sr) begin
                    errors++;
                    $display("FAIL %s stats: got %0d/%0d/%0d expected %0d/%0d/%0d", e.nm,
                             stat_lookups, stat_hits, stat_redirects, e.sl, e.sh, e.sr);
                end
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //    name        rst  pc       st    fl    ue    upd_pc   ut    target   ck      hit   nxt      idex
        step("rst0",     1'b1, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0040, 3'b000, 1'b0, 16'h0000, 1'b0);
        step("reset",    1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("alloc",    1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0040, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("hit1",     1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h0040, 1'b0);
        step("pipe0",    1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("pipe1",    1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b1);
        step("nt1",      1'b0, 16'h0105, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("nt2",      1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("nt_sat",   1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("t_00",     1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0044, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("t_01",     1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0048, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("t_10",     1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0048, 3'b111, 1'b1, 16'h0048, 1'b0);
        step("t_sat",    1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0048, 3'b111, 1'b1, 16'h0048, 1'b0);
        step("nt_11",    1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h0048, 1'b1);
        step("no_wrap",  1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h0048, 1'b1);
        step("alias_up", 1'b0, 16'h0105, 1'b0, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0080, 3'b111, 1'b0, 16'h0000, 1'b1);
        step("alias_old",1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b1);
        step("alias_new",1'b0, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h0080, 1'b0);
        step("miss_nt",  1'b0, 16'h0020, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h0080, 1'b0);
        step("miss_nt2", 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h0080, 1'b1);
        step("capture",  1'b0, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h0080, 1'b1);
        step("stall1",   1'b0, 16'h0020, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h0080, 1'b1);
        step("stall2",   1'b0, 16'h0020, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h0080, 1'b0);
        step("stall3",   1'b0, 16'h0020, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h0080, 1'b0);
        step("release",  1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("held_hit", 1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b1);
        step("drain",    1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("fl_capt",  1'b0, 16'h0020, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h0080, 1'b0);
        step("fl_a",     1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("fl_b",     1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("fl2_hit",  1'b0, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h0080, 1'b0);
        step("fl2_st",   1'b0, 16'h0105, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("fl2_a",    1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("fl2_b",    1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("same_cyc", 1'b0, 16'h0030, 1'b0, 1'b0, 1'b1, 16'h0030, 1'b1, 16'h00C0, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("same_nxt", 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b1, 16'h00C0, 1'b0);
        step("replaced", 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("same_pipe",1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b1);
        step("rst_mid",  1'b1, 16'h0030, 1'b0, 1'b0, 1'b1, 16'h0030, 1'b1, 16'h00C0, 3'b000, 1'b0, 16'h0000, 1'b0);
        step("post_rst", 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("rst_upd",  1'b0, 16'h0030, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("idx7_up",  1'b0, 16'h0105, 1'b0, 1'b0, 1'b1, 16'h1237, 1'b1, 16'hBEEF, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("idx7_hit", 1'b0, 16'h1237, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b1, 16'hBEEF, 1'b0);
        step("idx7_tag", 1'b0, 16'h2237, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b0);
        step("idx7_pipe",1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b111, 1'b0, 16'h0000, 1'b1);
`ifdef BTB_STATS_EN
        step("s_rst",    1'b1, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b000, 1'b0, 16'h0000, 1'b0);
        stat_chk = 1'b1; exp_sl = 16'd0; exp_sh = 16'd0; exp_sr = 16'd0;
        step("s1",       1'b0, 16'h0105, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0040, 3'b011, 1'b0, 16'h0000, 1'b0);
        step("s2",       1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b011, 1'b1, 16'h0040, 1'b0);
        step("s3",       1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b011, 1'b1, 16'h0040, 1'b0);
        step("s4",       1'b0, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b011, 1'b1, 16'h0040, 1'b0);
        step("s5",       1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b011, 1'b1, 16'h0040, 1'b0);
        step("s6",       1'b0, 16'h0105, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b011, 1'b0, 16'h0000, 1'b0);
        step("s7",       1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b011, 1'b1, 16'h0040, 1'b0);
        for (int i = 0; i < 4; i++)
            step("s_idle", 1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b011, 1'b0, 16'h0000, 1'b0);
        stat_chk = 1'b1; exp_sl = 16'd10; exp_sh = 16'd4; exp_sr = 16'd1;
        step("s_final",  1'b0, 16'h0105, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b011, 1'b0, 16'h0000, 1'b0);
`endif
        @(posedge clk);
        #1;
        upd_en = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
